// File: rtl/irq_pending_ctrl8.sv
// ============================================================================
// Module   : irq_pending_ctrl8
// Purpose  : 8-line interrupt capture (sync, edge/level pending, mask) with
//            request/ack/EOI handshake feeding an 8:3 priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_pending_ctrl8 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irq_in,
  input  logic [7:0] edge_sel,
  input  logic [7:0] mask,
  input  logic       ack,
  input  logic [2:0] ack_idx,
  input  logic       eoi,
  output logic [7:0] pend_out,
  output logic       irq_valid,
  output logic       in_service,
  output logic [2:0] isr_idx,
  output logic       spurious
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t                          r_state;
  logic [SYNC_STAGES-1:0][7:0]     r_sync;
  logic [7:0]                      r_prev;
  logic [7:0]                      r_pend;

  logic [7:0] w_sync;
  logic [7:0] w_rise;
  logic       w_ack_hit;
  logic       w_accept;
  logic [7:0] w_clr;
  logic [7:0] w_pend_nxt;

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_sync & ~r_prev;
  assign pend_out  = r_pend & ~mask;
  assign w_ack_hit = pend_out[ack_idx];
  assign w_accept  = (r_state == REQ) && ack && w_ack_hit;
  assign w_clr     = w_accept ? (8'b0000_0001 << ack_idx) : 8'b0;

  // A fresh edge on the line being acknowledged wins over the clear.
  assign w_pend_nxt = (edge_sel & (w_rise | (r_pend & ~w_clr)))
                    | (~edge_sel & w_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 8'h00;
      r_pend <= 8'h00;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irq_in};
      r_prev <= w_sync;
      r_pend <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      irq_valid  <= 1'b0;
      in_service <= 1'b0;
      isr_idx    <= 3'b000;
      spurious   <= 1'b0;
    end else begin
      spurious <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|pend_out) begin
            r_state   <= REQ;
            irq_valid <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            if (w_ack_hit) begin
              r_state    <= SERVICE;
              isr_idx    <= ack_idx;
              irq_valid  <= 1'b0;
              in_service <= 1'b1;
            end else begin
              spurious <= 1'b1;
            end
          end else if (pend_out == 8'h00) begin
            r_state   <= IDLE;
            irq_valid <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) begin
            r_state    <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          irq_valid  <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_pending_ctrl8.sv
// ============================================================================
// Module   : tb_irq_pending_ctrl8
// Purpose  : Directed self-checking bench for irq_pending_ctrl8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_pending_ctrl8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] edge_sel;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] ack_idx;
  logic       eoi;
  logic [7:0] pend_out;
  logic       irq_valid;
  logic       in_service;
  logic [2:0] isr_idx;
  logic       spurious;

  int n_tests = 0;
  int n_fail  = 0;

  irq_pending_ctrl8 #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_in     (irq_in),
    .edge_sel   (edge_sel),
    .mask       (mask),
    .ack        (ack),
    .ack_idx    (ack_idx),
    .eoi        (eoi),
    .pend_out   (pend_out),
    .irq_valid  (irq_valid),
    .in_service (in_service),
    .isr_idx    (isr_idx),
    .spurious   (spurious)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; irq_in = 8'h00; edge_sel = 8'hFF; mask = 8'h00;
    ack = 1'b0; ack_idx = 3'd0; eoi = 1'b0;
    tick(2);
    n_tests++;
    if ({pend_out, irq_valid, in_service, isr_idx, spurious} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pend=%h v=%b s=%b idx=%0d sp=%b, expected all 0",
               pend_out, irq_valid, in_service, isr_idx, spurious);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_latency;
    irq_in = 8'h20;
    tick(2);
    n_tests++;
    if (pend_out !== 8'h00) begin
      n_fail++; $display("FAIL lat_edge2_pend: got %h expected 00", pend_out);
    end
    tick(1);
    n_tests++;
    if (pend_out !== 8'h20 || irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_edge3: got pend=%h v=%b expected 20/0", pend_out, irq_valid);
    end
    tick(1);
    n_tests++;
    if (irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL lat_edge4_valid: got %b expected 1", irq_valid);
    end
  endtask

  task automatic test_ack_eoi;
    ack = 1'b1; ack_idx = 3'd5;
    tick(1);
    ack = 1'b0;
    n_tests++;
    if (in_service !== 1'b1 || isr_idx !== 3'd5 || pend_out !== 8'h00 || irq_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ack5: got s=%b idx=%0d pend=%h v=%b expected 1/5/00/0",
               in_service, isr_idx, pend_out, irq_valid);
    end
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    n_tests++;
    if (in_service !== 1'b0 || irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL eoi5: got s=%b v=%b expected 0/0", in_service, irq_valid);
    end
    tick(1);
    n_tests++;
    if (irq_valid !== 1'b0 || isr_idx !== 3'd5) begin
      n_fail++; $display("FAIL idle_after_eoi: got v=%b idx=%0d expected 0/5", irq_valid, isr_idx);
    end
    irq_in = 8'h00;
    tick(4);
  endtask

  task automatic test_back_to_back;
    irq_in = 8'h42;
    tick(4);
    n_tests++;
    if (pend_out !== 8'h42 || irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_req: got pend=%h v=%b expected 42/1", pend_out, irq_valid);
    end
    ack = 1'b1; ack_idx = 3'd6;
    tick(1);
    ack = 1'b0;
    n_tests++;
    if (pend_out !== 8'h02 || in_service !== 1'b1 || isr_idx !== 3'd6) begin
      n_fail++;
      $display("FAIL b2b_ack6: got pend=%h s=%b idx=%0d expected 02/1/6", pend_out, in_service, isr_idx);
    end
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    n_tests++;
    if (irq_valid !== 1'b0 || in_service !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle_gap: got v=%b s=%b expected 0/0", irq_valid, in_service);
    end
    tick(1);
    n_tests++;
    if (irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_rereq: got v=%b expected 1", irq_valid);
    end
    ack = 1'b1; ack_idx = 3'd1;
    tick(1);
    ack = 1'b0; eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    n_tests++;
    if (pend_out !== 8'h00 || isr_idx !== 3'd1 || in_service !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ack1: got pend=%h idx=%0d s=%b expected 00/1/0", pend_out, isr_idx, in_service);
    end
    irq_in = 8'h00;
    tick(4);
  endtask

  task automatic test_level;
    edge_sel = 8'hFB; irq_in = 8'h04;
    tick(4);
    n_tests++;
    if (pend_out !== 8'h04 || irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL lvl_req: got pend=%h v=%b expected 04/1", pend_out, irq_valid);
    end
    ack = 1'b1; ack_idx = 3'd2;
    tick(1);
    ack = 1'b0;
    n_tests++;
    if (pend_out !== 8'h04 || in_service !== 1'b1 || isr_idx !== 3'd2) begin
      n_fail++;
      $display("FAIL lvl_ack_noclr: got pend=%h s=%b idx=%0d expected 04/1/2", pend_out, in_service, isr_idx);
    end
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    tick(1);
    n_tests++;
    if (irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL lvl_rereq: got v=%b expected 1", irq_valid);
    end
    irq_in = 8'h00;
    tick(3);
    n_tests++;
    if (pend_out !== 8'h00 || irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL lvl_drop_pend: got pend=%h v=%b expected 00/1", pend_out, irq_valid);
    end
    tick(1);
    n_tests++;
    if (irq_valid !== 1'b0 || spurious !== 1'b0) begin
      n_fail++; $display("FAIL lvl_withdraw: got v=%b sp=%b expected 0/0", irq_valid, spurious);
    end
    edge_sel = 8'hFF;
    tick(1);
  endtask

  task automatic test_spurious_mask;
    irq_in = 8'h10;
    tick(4);
    ack = 1'b1; ack_idx = 3'd0;
    tick(1);
    ack = 1'b0;
    n_tests++;
    if (spurious !== 1'b1 || irq_valid !== 1'b1 || in_service !== 1'b0 || pend_out !== 8'h10) begin
      n_fail++;
      $display("FAIL spur_pulse: got sp=%b v=%b s=%b pend=%h expected 1/1/0/10",
               spurious, irq_valid, in_service, pend_out);
    end
    tick(1);
    n_tests++;
    if (spurious !== 1'b0 || irq_valid !== 1'b1) begin
      n_fail++; $display("FAIL spur_one_cycle: got sp=%b v=%b expected 0/1", spurious, irq_valid);
    end
    mask = 8'h10;
    #1;
    n_tests++;
    if (pend_out !== 8'h00) begin
      n_fail++; $display("FAIL mask_same_cycle: got %h expected 00", pend_out);
    end
    tick(1);
    n_tests++;
    if (irq_valid !== 1'b0) begin
      n_fail++; $display("FAIL mask_idle: got v=%b expected 0", irq_valid);
    end
    mask = 8'h00;
    tick(1);
    n_tests++;
    if (irq_valid !== 1'b1 || pend_out !== 8'h10) begin
      n_fail++; $display("FAIL unmask_rereq: got v=%b pend=%h expected 1/10", irq_valid, pend_out);
    end
    ack = 1'b1; ack_idx = 3'd4;
    tick(1);
    ack = 1'b0; eoi = 1'b1;
    tick(1);
    eoi = 1'b0; irq_in = 8'h00;
    tick(4);
  endtask

  task automatic test_collision_reset;
    irq_in = 8'h08;
    tick(4);
    n_tests++;
    if (irq_valid !== 1'b1 || pend_out !== 8'h08) begin
      n_fail++; $display("FAIL col_req: got v=%b pend=%h expected 1/08", irq_valid, pend_out);
    end
    irq_in = 8'h00;
    tick(2);
    irq_in = 8'h08;
    tick(2);
    ack = 1'b1; ack_idx = 3'd3;
    tick(1);
    ack = 1'b0;
    n_tests++;
    if (in_service !== 1'b1 || isr_idx !== 3'd3 || pend_out !== 8'h08) begin
      n_fail++;
      $display("FAIL col_edge_wins: got s=%b idx=%0d pend=%h expected 1/3/08", in_service, isr_idx, pend_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({pend_out, irq_valid, in_service, isr_idx, spurious} !== 14'h0) begin
      n_fail++;
      $display("FAIL async_reset: got pend=%h v=%b s=%b idx=%0d sp=%b expected all 0",
               pend_out, irq_valid, in_service, isr_idx, spurious);
    end
    irq_in = 8'h00;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ack_eoi();
    test_back_to_back();
    test_level();
    test_spurious_mask();
    test_collision_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/irq_pending_ctrl8.md
Name: irq_pending_ctrl8

Overview:
- Upstream request-capture stage for the 8:3 priority encoder.
- Synchronises 8 asynchronous interrupt lines and detects edges or levels per line.
- Holds a pending register, applies a mask, and presents the masked pending vector as the encoder's d input.
- Runs a request/acknowledge/end-of-interrupt handshake with the servicing controller. The controller returns the encoder's 3-bit index as ack_idx.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on irq_in (legal range 2..3).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- irq_in  input  8  raw asynchronous interrupt lines.
- edge_sel  input  8  per-line mode; 1 = rising-edge latched, 0 = level.
- mask  input  8  per-line mask; 1 = line blocked from pend_out.
- ack  input  1  single-cycle acknowledge pulse from controller.
- ack_idx  input  3  index being acknowledged, from the priority encoder output.
- eoi  input  1  single-cycle end-of-interrupt pulse.
- pend_out  output  8  pend_q & ~mask; drives encoder d.
- irq_valid  output  1  high while in state REQ.
- in_service  output  1  high while in state SERVICE.
- isr_idx  output  3  index captured on the accepted ack.
- spurious  output  1  one-cycle pulse on a rejected ack.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - Synchroniser flops, prev_q and pend_q are 0.
  - State is IDLE.
  - pend_out, irq_valid, in_service and spurious are 0; isr_idx is 3'b000.
- Synchroniser: an SYNC_STAGES-deep flop chain per line produces sync[7:0]. prev_q is sync delayed by one cycle. rise = sync & ~prev_q.
- Pending register, edge lines (edge_sel[i]=1):
  - pend_q[i] sets on rise[i].
  - pend_q[i] clears on an accepted ack with ack_idx==i.
  - A set and a clear in the same cycle leave the bit set (a new edge wins).
- Pending register, level lines (edge_sel[i]=0): pend_q[i] <= sync[i] every cycle; ack does not clear it.
- Changing edge_sel[i] takes effect on the next clock edge and does not clear pend_q[i].
- pend_out is combinational from pend_q and mask, so masking takes effect in the same cycle.
- FSM states and transitions:
  - IDLE -> REQ when |pend_out.
  - REQ -> SERVICE on ack with pend_out[ack_idx]==1. On that edge, capture isr_idx<=ack_idx and clear the edge bit.
  - REQ, ack with pend_out[ack_idx]==0: stay in REQ, spurious=1 on the next cycle only, pend_q unchanged.
  - REQ -> IDLE when pend_out==0 and no ack (request withdrawn by mask or level drop).
  - SERVICE -> IDLE on eoi. Acks in SERVICE are ignored (no spurious pulse). Pending bits keep accumulating in SERVICE.
  - eoi in IDLE or REQ is ignored.
  - isr_idx holds its value until the next accepted ack.
- Latency: an irq_in rise held at least SYNC_STAGES+1 cycles gives pend_out valid SYNC_STAGES+1 edges later, and irq_valid one edge after that (4 edges at default).
- Back-to-back: eoi returns to IDLE. If pend_out is non-zero, REQ follows on the next edge, giving one IDLE cycle minimum between services.
- Glitches: input pulses shorter than one clock are not guaranteed to be captured.
- Reset mid-operation: asserting rst_n low in any state returns all state to reset values immediately. Pending edges are lost.

Test Plan:
- Reset, irq_in=8'h00 -> all outputs 0, state IDLE. Then edge_sel=8'hFF, irq_in[5] 0->1 -> pend_out=8'h20 after 3 edges, irq_valid=1 after 4.
- In REQ with pend_out=8'h20, ack with ack_idx=3'd5 -> in_service=1, isr_idx=5, pend_out=8'h00. eoi -> in_service=0, state IDLE, irq_valid stays 0.
- Edge lines 1 and 6 both pending (pend_out=8'h42), ack_idx=6 then eoi -> pend_out=8'h02, irq_valid reasserts one cycle after IDLE. ack_idx=1, eoi -> pend_out=8'h00.
- Level line 2 (edge_sel[2]=0) held high, ack_idx=2 then eoi -> pend_out[2] stays 1 and REQ recurs. Drop irq_in[2] while in REQ -> pend_out=0 after sync delay, FSM returns to IDLE, no spurious pulse.
- In REQ with pend_out=8'h10, ack with ack_idx=3'd0 -> spurious pulses 1 cycle, state stays REQ, pend_out=8'h10. Set mask=8'h10 -> pend_out=0 same cycle, IDLE next edge.
- Edge line 3 accepted: in the same cycle as ack_idx=3, a new rise arrives on line 3 -> pend_out[3] remains 1. Then assert rst_n=0 during SERVICE -> all outputs 0 immediately.
